// File: rtl/arbiter_merge_rr_pkg.sv
// Shared types for the round-robin merge: source index and FIFO entry layout {src, data},
// so downstream blocks decode out_src identically.
package arbiter_merge_rr_pkg;

   localparam int NUM_IN_DEF = 4;
   localparam int WIDTH_DEF  = 33;
   localparam int SRC_W_DEF  = $clog2(NUM_IN_DEF);

   typedef logic [SRC_W_DEF-1:0] src_idx_t;

   typedef struct packed {
      src_idx_t               src;
      logic [WIDTH_DEF-1:0]   data;
   } merge_entry_t;

   // Pointer step after a grant to input g: wrap to 0 past the last input.
   function automatic int rr_next(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/merge_fifo.sv
// Synchronous circular-buffer FIFO holding {src, data} entries for the merge output.
// Head data reads as zero while empty so the output bus is clean after reset.
module merge_fifo
   import arbiter_merge_rr_pkg::*;
#(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/arbiter_merge_rr.sv
// N-input round-robin arbitrated merge into a registered output FIFO.
// Each output word carries the index of the input it came from.
module arbiter_merge_rr
   import arbiter_merge_rr_pkg::*;
#(
   parameter int  NUM_IN = 4,
   parameter int  WIDTH  = 33,
   parameter int  DEPTH  = 4,
   localparam int ID_W   = $clog2(NUM_IN),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic [NUM_IN-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [ID_W-1:0]         out_src,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        occupancy
);

   logic [ID_W-1:0]      rr_q, rr_d;
   logic [ID_W-1:0]      gnt_idx, idx;
   logic                 found;
   logic [NUM_IN-1:0]    grant;
   logic                 push, full, empty;
   logic [ID_W+WIDTH-1:0] wentry, rentry;

   // Search from rr_q upward with wrap; only full, rst and in_valid gate the grant,
   // so out_ready never reaches in_ready combinationally.
   always_comb begin
      gnt_idx = '0;
      idx     = '0;
      found   = 1'b0;
      grant   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = ID_W'((int'(rr_q) + k) % NUM_IN);
         if (!found && in_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
      if (found && !full && !rst) grant[gnt_idx] = 1'b1;
   end

   assign in_ready = grant;
   assign push     = |grant;
   assign rr_d     = push ? ID_W'(rr_next(int'(gnt_idx), NUM_IN)) : rr_q;
   assign wentry   = {gnt_idx, in_data[int'(gnt_idx)*WIDTH +: WIDTH]};

   always_ff @(posedge clk) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
   end

   merge_fifo #(
      .WIDTH (ID_W + WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (wentry),
      .pop_i   (out_ready),
      .rdata_o (rentry),
      .full_o  (full),
      .empty_o (empty),
      .count_o (occupancy)
   );

   assign out_valid = ~empty;
   assign out_src   = rentry[ID_W+WIDTH-1 -: ID_W];
   assign out_data  = rentry[WIDTH-1:0];

endmodule

// File: tb/tb_arbiter_merge_rr.sv
// Directed bench for arbiter_merge_rr (NUM_IN=4, WIDTH=33, DEPTH=4).
module tb_arbiter_merge_rr;

   localparam int NUM_IN = 4;
   localparam int WIDTH  = 33;
   localparam int DEPTH  = 4;

   logic                    clk;
   logic                    rst;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [1:0]              out_src;
   logic                    out_ready;
   logic [2:0]              occupancy;

   int errors = 0;
   int checks = 0;

   arbiter_merge_rr #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] dval(input int i);
      return 33'h1_5A5A_0000 + WIDTH'(i * 17);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int i, input logic [WIDTH-1:0] v);
      in_data[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic head(input string tag, input int src, input int occ);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_src"},   64'(out_src),   64'(src));
      chk({tag, "_data"},  64'(out_data),  64'(dval(src)));
      chk({tag, "_occ"},   64'(occupancy), 64'(occ));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < NUM_IN; i++) set_word(i, dval(i));

      // Reset held three cycles with every input requesting.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("rst_in_ready",  64'(in_ready),  64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_occ",       64'(occupancy), 64'd0);
         chk("rst_out_data",  64'(out_data),  64'd0);
         chk("rst_out_src",   64'(out_src),   64'd0);
      end

      // Single source on input 2.
      @(negedge clk);
      rst = 1'b0; in_valid = 4'b0100; out_ready = 1'b1;
      set_word(2, 33'h1_0000_00AA);
      #1 chk("single_grant", 64'(in_ready), 64'b0100);
      @(negedge clk);
      in_valid = 4'b0000;
      #1;
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_data",  64'(out_data),  64'h1_0000_00AA);
      chk("single_src",   64'(out_src),   64'd2);
      chk("single_occ",   64'(occupancy), 64'd1);
      set_word(2, dval(2));
      @(negedge clk); #1;
      chk("single_drain", 64'(out_valid), 64'd0);

      // Fairness: reset the pointer, then all four inputs continuously valid.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
      #1 chk("fair_grant0", 64'(in_ready), 64'b0001);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk); #1;
         chk("fair_grant", 64'(in_ready), 64'(4'b0001 << (k % 4)));
         head("fair_head", (k - 1) % 4, 1);
      end
      @(negedge clk);
      in_valid = 4'b0000;
      #1 head("fair_last", 3, 1);
      @(negedge clk); #1;
      chk("fair_empty", 64'(out_valid), 64'd0);

      // Backpressure: fill to DEPTH with out_ready low.
      in_valid = 4'b1111; out_ready = 1'b0;
      #1 chk("bp_grant0", 64'(in_ready), 64'b0001);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk); #1;
         chk("bp_grant", 64'(in_ready), 64'(4'b0001 << k));
         chk("bp_occ",   64'(occupancy), 64'(k));
      end
      @(negedge clk); #1;
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      head("bp_full", 0, 4);
      out_ready = 1'b1;
      #1 chk("bp_full_no_push", 64'(in_ready), 64'd0);
      @(negedge clk); #1;
      head("bp_pop1", 1, 3);
      chk("bp_resume", 64'(in_ready), 64'b0001);
      @(negedge clk); #1;
      head("bp_pop2", 2, 3);
      chk("bp_resume2", 64'(in_ready), 64'b0010);
      in_valid = 4'b0000;
      @(negedge clk); #1;
      head("bp_pop3", 3, 2);
      @(negedge clk); #1;
      head("bp_pop4", 0, 1);
      @(negedge clk); #1;
      chk("bp_empty", 64'(occupancy), 64'd0);

      // Wrap/skip: grant 3, then 4'b1010 must go to 1 then 3.
      in_valid = 4'b1000;
      #1 chk("wrap_g3", 64'(in_ready), 64'b1000);
      @(negedge clk);
      in_valid = 4'b1010;
      #1;
      chk("wrap_g1", 64'(in_ready), 64'b0010);
      head("wrap_h3", 3, 1);
      @(negedge clk); #1;
      chk("wrap_g3b", 64'(in_ready), 64'b1000);
      head("wrap_h1", 1, 1);
      @(negedge clk);
      in_valid = 4'b0000;
      #1 head("wrap_h3b", 3, 1);
      @(negedge clk); #1;
      chk("wrap_empty", 64'(out_valid), 64'd0);

      // Mid-operation reset with three words queued; pointer would be at 3.
      in_valid = 4'b1111; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); #1;
      chk("mid_occ3",  64'(occupancy), 64'd3);
      chk("mid_pre",   64'(in_ready),  64'b1000);
      rst = 1'b1;
      #1 chk("mid_rst_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_occ0",   64'(occupancy), 64'd0);
      chk("mid_valid0", 64'(out_valid), 64'd0);
      chk("mid_data0",  64'(out_data),  64'd0);
      chk("mid_grant0", 64'(in_ready),  64'b0001);
      @(negedge clk); #1;
      head("mid_after", 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
